// File: rtl/oven_countdown.sv
// Oven cook-time countdown: latches a clamped MM:SS BCD time, counts it down once per
// TICK_DIV clocks while heating, with synchronized start/pause and cancel buttons.
module oven_countdown #(
   parameter int TICK_DIV = 50_000_000,
   parameter int BTN_SYNC = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] t3,
   input  logic [3:0] t2,
   input  logic [3:0] t1,
   input  logic [3:0] t0,
   input  logic       start_n,
   input  logic       cancel_n,
   output logic [3:0] hex3,
   output logic [3:0] hex2,
   output logic [3:0] hex1,
   output logic [3:0] hex0,
   output logic       heat,
   output logic       done,
   output logic       busy
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOADED = 3'd1,
      S_RUN    = 3'd2,
      S_PAUSE  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [15:0]           time_q, time_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [BTN_SYNC-1:0]   start_sync_q, start_sync_d;
   logic [BTN_SYNC-1:0]   cancel_sync_q, cancel_sync_d;
   logic                  start_prev_q, cancel_prev_q;
   logic                  heat_q, heat_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;

   logic                  start_press, cancel_press;
   logic                  tick;
   logic [15:0]           load_val;
   logic                  load_nz;
   logic [15:0]           dec_val;

   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
      return (d > lim) ? lim : d;
   endfunction

   function automatic logic [15:0] clamp_time(input logic [3:0] a, input logic [3:0] b,
                                              input logic [3:0] c, input logic [3:0] d);
      return {clamp_digit(a, 4'd9), clamp_digit(b, 4'd9),
              clamp_digit(c, 4'd5), clamp_digit(d, 4'd9)};
   endfunction

   // Borrow chain: seconds ones -> seconds tens (0..5) -> minutes ones -> minutes tens.
   function automatic logic [15:0] bcd_dec(input logic [15:0] t);
      logic [3:0] d3, d2, d1, d0;
      {d3, d2, d1, d0} = t;
      if (t == 16'h0000) return 16'h0000;
      if (d0 != 4'd0) d0 = d0 - 4'd1;
      else begin
         d0 = 4'd9;
         if (d1 != 4'd0) d1 = d1 - 4'd1;
         else begin
            d1 = 4'd5;
            if (d2 != 4'd0) d2 = d2 - 4'd1;
            else begin
               d2 = 4'd9;
               d3 = d3 - 4'd1;
            end
         end
      end
      return {d3, d2, d1, d0};
   endfunction

   // Button synchronizers and falling-edge detectors.
   always_comb begin
      start_sync_d  = {start_sync_q[BTN_SYNC-2:0], start_n};
      cancel_sync_d = {cancel_sync_q[BTN_SYNC-2:0], cancel_n};
   end

   assign start_press  = start_prev_q  & ~start_sync_q[BTN_SYNC-1];
   assign cancel_press = cancel_prev_q & ~cancel_sync_q[BTN_SYNC-1];
   assign tick         = (presc_q == PRESC_LAST);
   assign load_val     = clamp_time(t3, t2, t1, t0);
   assign load_nz      = (load_val != 16'h0000);
   assign dec_val      = bcd_dec(time_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         time_q        <= 16'h0000;
         presc_q       <= '0;
         start_sync_q  <= '1;
         cancel_sync_q <= '1;
         start_prev_q  <= 1'b1;
         cancel_prev_q <= 1'b1;
         heat_q        <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         time_q        <= time_d;
         presc_q       <= presc_d;
         start_sync_q  <= start_sync_d;
         cancel_sync_q <= cancel_sync_d;
         start_prev_q  <= start_sync_q[BTN_SYNC-1];
         cancel_prev_q <= cancel_sync_q[BTN_SYNC-1];
         heat_q        <= heat_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
      end
   end

   // Priority everywhere: cancel, then start, then tick/load.
   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      presc_d = presc_q;
      case (state_q)
         S_IDLE: begin
            if (load && load_nz) begin
               state_d = S_LOADED;
               time_d  = load_val;
            end
         end
         S_LOADED: begin
            if (cancel_press) begin
               state_d = S_IDLE;
               time_d  = 16'h0000;
            end else if (start_press) begin
               state_d = S_RUN;
               presc_d = '0;
            end else if (load) begin
               state_d = load_nz ? S_LOADED : S_IDLE;
               time_d  = load_val;
            end
         end
         S_RUN: begin
            if (cancel_press) begin
               state_d = S_IDLE;
               time_d  = 16'h0000;
            end else if (tick) begin
               presc_d = '0;
               time_d  = dec_val;
               if (dec_val == 16'h0000) state_d = S_DONE;
               else if (start_press)    state_d = S_PAUSE;
            end else if (start_press) begin
               state_d = S_PAUSE;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         S_PAUSE: begin
            if (cancel_press) begin
               state_d = S_IDLE;
               time_d  = 16'h0000;
            end else if (start_press) begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            time_d = 16'h0000;
            if (cancel_press || start_press) begin
               state_d = S_IDLE;
            end else if (load && load_nz) begin
               state_d = S_LOADED;
               time_d  = load_val;
            end
         end
         default: begin
            state_d = S_IDLE;
            time_d  = 16'h0000;
         end
      endcase
   end

   always_comb begin
      heat_d = (state_d == S_RUN);
      done_d = (state_d == S_DONE);
      busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
   end

   assign {hex3, hex2, hex1, hex0} = time_q;
   assign heat = heat_q;
   assign done = done_q;
   assign busy = busy_q;

endmodule
